mux4way_stream_arbiter: RTL
===========================

# mux4way_stream_arbiter

Four-to-one sequential stream merger: the return-path counterpart of the 4-way demultiplexer, gathering words from four valid/ready sources `a`..`d` onto one output stream. Round-robin arbitration with packet locking (a granted source keeps the output until it delivers a `last` word). One registered output stage, so the output is glitch-free and 1-cycle latent. It sits in front of shared Hack-word consumers (memory/IO write port) fed by several producers.

## Interface
- `WIDTH`, 16, data word width (Hack word).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_a`, `in_b`, `in_c`, `in_d`  in  WIDTH  source data words.
- `valid_a`..`valid_d`  in  1  source word present.
- `last_a`..`last_d`  in  1  word is final word of its packet.
- `ready_a`..`ready_d`  out  1  source word accepted this cycle when valid&ready.
- `out`  out  WIDTH  registered output word.
- `out_last`  out  1  registered copy of accepted word's last flag.
- `out_sel`  out  2  index of source of `out` (00=a, 01=b, 10=c, 11=d).
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts `out` when out_valid&out_ready.

## Operation
- State: output register (`out`, `out_last`, `out_sel`, `out_valid`), round-robin pointer `ptr[1:0]`, lock flag `locked`, locked index `lidx[1:0]`.
- Arbitration states: IDLE (`locked`=0) and LOCKED (`locked`=1).
- `can_load` = !out_valid | out_ready.
- IDLE grant: first source with valid=1 scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). No valid source -> no grant.
- LOCKED grant: `lidx` only, regardless of other valids; if that source is not valid, no grant (bubble) and lock held.
- `ready_x` = can_load & (grant == x). At most one ready high per cycle. Ready may depend combinationally on valid; sources must not make valid depend on ready.
- Accept (granted source valid & ready): load `out`<=data, `out_last`<=last, `out_sel`<=idx, `out_valid`<=1.
  - last=1: `locked`<=0, `ptr`<=idx+1 mod 4 (3 wraps to 0).
  - last=0: `locked`<=1, `lidx`<=idx; ptr unchanged.
- No accept and out_valid&out_ready: `out_valid`<=0; data fields hold.
- No accept and !out_ready: register holds unchanged.
- Single-word packets (last=1 every word) reduce to plain round-robin mux.
- Sources must hold data/last stable while valid and not ready.

## Timing
- Reset (rst_n=0, immediate, clock-independent): `out`=0, `out_last`=0, `out_sel`=00, `out_valid`=0, `ptr`=00, `locked`=0; all `ready_x`=0 while reset asserted is not required but grants begin from a at first edge after release.
- Latency: source handshake at edge N -> `out_valid`=1 with that word after edge N.
- Throughput: 1 word/cycle with out_ready held 1 (drain and load in same cycle).
- Backpressure: out_valid=1 & out_ready=0 -> all `ready_x`=0 next evaluation; `out` stable until taken.
- Simultaneous valid on all four, out_ready=1, single-word packets, ptr=0: accepted order a,b,c,d,a,...
- Reset mid-packet: lock cleared, word in output register discarded, arbitration restarts at a.

## Test plan
- Reset: hold rst_n=0 with all valids=1 -> out_valid=0, out=0, out_sel=00; release -> first accept from a, out_valid=1 one cycle later.
- Round-robin: all four valid, last=1, data a=0x1111,b=0x2222,c=0x3333,d=0x4444, out_ready=1 -> out sequence 1111,2222,3333,4444,1111 with out_sel 0,1,2,3,0, one word per cycle.
- Packet lock: b sends 3 words (last on 3rd) while a,c,d valid -> out_sel=01 for 3 consecutive words, then c (ptr=2) next.
- Lock bubble: c granted with last=0, then valid_c drops 2 cycles while a valid -> ready_a stays 0, out_valid drops to 0, c resumes and completes packet before a served.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out/out_sel constant, all ready_x=0; raise out_ready -> drain and next load in same cycle.
- Wrap and mid-packet reset: ptr=3, only d and a valid -> d then a; assert rst_n=0 during a 4-word packet from a -> out_valid=0 immediately, after release b (if only b valid) granted at once.

Source files
------------

// File: rtl/mux4way_stream_arbiter.sv
// Four-to-one valid/ready stream merger with round-robin arbitration, packet locking
// and a single registered output stage.
module mux4way_stream_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic             valid_a,
  input  logic             valid_b,
  input  logic             valid_c,
  input  logic             valid_d,
  input  logic             last_a,
  input  logic             last_b,
  input  logic             last_c,
  input  logic             last_d,
  output logic             ready_a,
  output logic             ready_b,
  output logic             ready_c,
  output logic             ready_d,
  output logic [WIDTH-1:0] out,
  output logic             out_last,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       lidx_q;
  logic [WIDTH-1:0] out_q;
  logic             out_last_q;
  logic [1:0]       out_sel_q;
  logic             out_valid_q;

  logic [3:0]       valid_vec;
  logic [3:0]       last_vec;
  logic [WIDTH-1:0] data_vec [4];
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             can_load;
  logic             accept;
  logic [3:0]       ready_vec;

  assign valid_vec   = {valid_d, valid_c, valid_b, valid_a};
  assign last_vec    = {last_d, last_c, last_b, last_a};
  assign data_vec[0] = in_a;
  assign data_vec[1] = in_b;
  assign data_vec[2] = in_c;
  assign data_vec[3] = in_d;

  // Descending scan so the candidate closest to ptr_q is assigned last and wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    if (state_q == StLocked) begin
      grant_idx = lidx_q;
      grant_vld = valid_vec[lidx_q];
    end else begin
      for (int k = 3; k >= 0; k--) begin
        cand = ptr_q + 2'(k);
        if (valid_vec[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign can_load  = !out_valid_q || out_ready;
  assign accept    = can_load && grant_vld;
  assign ready_vec = accept ? (4'b0001 << grant_idx) : 4'b0000;

  assign ready_a   = ready_vec[0];
  assign ready_b   = ready_vec[1];
  assign ready_c   = ready_vec[2];
  assign ready_d   = ready_vec[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      lidx_q      <= 2'd0;
      out_q       <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 2'd0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= data_vec[grant_idx];
      out_last_q  <= last_vec[grant_idx];
      out_sel_q   <= grant_idx;
      out_valid_q <= 1'b1;
      if (last_vec[grant_idx]) begin
        state_q <= StIdle;
        ptr_q   <= grant_idx + 2'd1;
      end else begin
        state_q <= StLocked;
        lidx_q  <= grant_idx;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out       = out_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
